// File: rtl/accel_dma_host.sv
// accel_dma_host: bus initiator that copies len words from src to dst with one transaction in flight.
// Build option ACCEL_DMA_ERR_EN: a response with host_err_i ends the transfer as aborted.
module accel_dma_host #(
   parameter int BusWidth = 32,
   parameter int LenWidth = 16
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start_i,
   input  logic                    abort_i,
   input  logic [BusWidth-1:0]     src_addr_i,
   input  logic [BusWidth-1:0]     dst_addr_i,
   input  logic [LenWidth-1:0]     len_i,
   input  logic                    src_incr_i,
   input  logic                    dst_incr_i,
   input  logic                    irq_clr_i,
   output logic                    busy_o,
   output logic                    done_o,
   output logic                    aborted_o,
   output logic                    irq_o,
   output logic [LenWidth-1:0]     words_done_o,
   output logic                    host_req_o,
   output logic [BusWidth-1:0]     host_addr_o,
   output logic                    host_we_o,
   output logic [BusWidth-1:0]     host_wdata_o,
   output logic [BusWidth/8-1:0]   host_be_o,
   input  logic                    host_gnt_i,
   input  logic                    host_rvalid_i,
   input  logic [BusWidth-1:0]     host_rdata_i,
   input  logic                    host_err_i
);

   localparam logic [BusWidth-1:0] WordStep = {{(BusWidth-3){1'b0}}, 3'b100};

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_RD_REQ  = 3'd1,
      S_RD_WAIT = 3'd2,
      S_WR_REQ  = 3'd3,
      S_WR_WAIT = 3'd4,
      S_DONE    = 3'd5
   } state_e;

   state_e              state_q;
   logic [BusWidth-1:0] src_q, dst_q, data_q, addr_q;
   logic [LenWidth-1:0] len_q, words_q;
   logic                src_incr_q, dst_incr_q, abort_q;
   logic                busy_q, done_q, aborted_q, irq_q, req_q, we_q;

   logic [BusWidth-1:0] src_next_d, dst_next_d;
   logic [LenWidth-1:0] words_next_d;
   logic                abort_pend_d, rsp_err_d;

`ifdef ACCEL_DMA_ERR_EN
   assign rsp_err_d = host_err_i;
`else
   logic unused_err_s;
   assign unused_err_s = host_err_i;
   assign rsp_err_d    = 1'b0;
`endif

   // Next word addresses/count and the abort request seen this cycle or earlier
   always_comb begin
      abort_pend_d = abort_q | abort_i;
      words_next_d = words_q + {{(LenWidth-1){1'b0}}, 1'b1};
      if (src_incr_q) begin
         src_next_d = src_q + WordStep;
      end else begin
         src_next_d = src_q;
      end
      if (dst_incr_q) begin
         dst_next_d = dst_q + WordStep;
      end else begin
         dst_next_d = dst_q;
      end
   end

   // Transfer FSM with registered bus and status outputs
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= S_IDLE;
         src_q      <= {BusWidth{1'b0}};
         dst_q      <= {BusWidth{1'b0}};
         data_q     <= {BusWidth{1'b0}};
         addr_q     <= {BusWidth{1'b0}};
         len_q      <= {LenWidth{1'b0}};
         words_q    <= {LenWidth{1'b0}};
         src_incr_q <= 1'b0;
         dst_incr_q <= 1'b0;
         abort_q    <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         aborted_q  <= 1'b0;
         irq_q      <= 1'b0;
         req_q      <= 1'b0;
         we_q       <= 1'b0;
      end else begin
         done_q <= 1'b0;
         // a completion later in this block overrides the clear
         if (irq_clr_i) begin
            irq_q <= 1'b0;
         end
         if (busy_q && abort_i) begin
            abort_q <= 1'b1;
         end
         case (state_q)
            S_IDLE: begin
               if (start_i) begin
                  src_q      <= src_addr_i;
                  dst_q      <= dst_addr_i;
                  len_q      <= len_i;
                  src_incr_q <= src_incr_i;
                  dst_incr_q <= dst_incr_i;
                  words_q    <= {LenWidth{1'b0}};
                  aborted_q  <= 1'b0;
                  abort_q    <= 1'b0;
                  busy_q     <= 1'b1;
                  if (len_i == {LenWidth{1'b0}}) begin
                     state_q <= S_DONE;
                     done_q  <= 1'b1;
                     irq_q   <= 1'b1;
                  end else begin
                     state_q <= S_RD_REQ;
                     req_q   <= 1'b1;
                     we_q    <= 1'b0;
                     addr_q  <= src_addr_i;
                  end
               end
            end
            S_RD_REQ: begin
               if (host_gnt_i) begin
                  req_q   <= 1'b0;
                  state_q <= S_RD_WAIT;
               end
            end
            S_RD_WAIT: begin
               if (host_rvalid_i) begin
                  data_q <= host_rdata_i;
                  if (rsp_err_d || abort_pend_d) begin
                     state_q   <= S_DONE;
                     done_q    <= 1'b1;
                     irq_q     <= 1'b1;
                     aborted_q <= 1'b1;
                  end else begin
                     state_q <= S_WR_REQ;
                     req_q   <= 1'b1;
                     we_q    <= 1'b1;
                     addr_q  <= dst_q;
                  end
               end
            end
            S_WR_REQ: begin
               if (host_gnt_i) begin
                  req_q   <= 1'b0;
                  state_q <= S_WR_WAIT;
               end
            end
            S_WR_WAIT: begin
               if (host_rvalid_i) begin
                  we_q <= 1'b0;
                  if (rsp_err_d) begin
                     state_q   <= S_DONE;
                     done_q    <= 1'b1;
                     irq_q     <= 1'b1;
                     aborted_q <= 1'b1;
                  end else begin
                     words_q <= words_next_d;
                     src_q   <= src_next_d;
                     dst_q   <= dst_next_d;
                     if (words_next_d == len_q) begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                        irq_q   <= 1'b1;
                     end else if (abort_pend_d) begin
                        state_q   <= S_DONE;
                        done_q    <= 1'b1;
                        irq_q     <= 1'b1;
                        aborted_q <= 1'b1;
                     end else begin
                        state_q <= S_RD_REQ;
                        req_q   <= 1'b1;
                        addr_q  <= src_next_d;
                     end
                  end
               end
            end
            S_DONE: begin
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
            end
            default: begin
               state_q <= S_IDLE;
               req_q   <= 1'b0;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign busy_o       = busy_q;
   assign done_o       = done_q;
   assign aborted_o    = aborted_q;
   assign irq_o        = irq_q;
   assign words_done_o = words_q;
   assign host_req_o   = req_q;
   assign host_addr_o  = addr_q;
   assign host_we_o    = we_q;
   assign host_wdata_o = data_q;
   assign host_be_o    = {(BusWidth/8){1'b1}};

endmodule

// File: tb/tb_accel_dma_host.sv
// Self-checking bench for accel_dma_host: table vectors, hand-written corner sequences and
// randomized transfers checked against a transaction-list model of the copy.
module tb_accel_dma_host;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        start_i = 1'b0, abort_i, irq_clr_i = 1'b0;
   logic [31:0] src_addr_i = 32'h0, dst_addr_i = 32'h0;
   logic [15:0] len_i = 16'h0;
   logic        src_incr_i = 1'b0, dst_incr_i = 1'b0;
   logic        busy_o, done_o, aborted_o, irq_o;
   logic [15:0] words_done_o;
   logic        host_req_o, host_we_o;
   logic [31:0] host_addr_o, host_wdata_o;
   logic [3:0]  host_be_o;
   logic        host_gnt_i, host_rvalid_i, host_err_i;
   logic [31:0] host_rdata_i;

   accel_dma_host #(.BusWidth(32), .LenWidth(16)) dut (
      .clk(clk), .rst(rst), .start_i(start_i), .abort_i(abort_i),
      .src_addr_i(src_addr_i), .dst_addr_i(dst_addr_i), .len_i(len_i),
      .src_incr_i(src_incr_i), .dst_incr_i(dst_incr_i), .irq_clr_i(irq_clr_i),
      .busy_o(busy_o), .done_o(done_o), .aborted_o(aborted_o), .irq_o(irq_o),
      .words_done_o(words_done_o), .host_req_o(host_req_o), .host_addr_o(host_addr_o),
      .host_we_o(host_we_o), .host_wdata_o(host_wdata_o), .host_be_o(host_be_o),
      .host_gnt_i(host_gnt_i), .host_rvalid_i(host_rvalid_i),
      .host_rdata_i(host_rdata_i), .host_err_i(host_err_i)
   );

   always #5 clk = ~clk;

   typedef struct { logic we; logic [31:0] addr; logic [31:0] data; } txn_t;
   typedef struct {
      string name; logic [31:0] src; logic [31:0] dst; logic [15:0] len;
      bit si; bit di; int gd; int rd; int exp_cycles; int exp_words;
   } vec_t;

   txn_t        log_q[$];
   txn_t        exp_q[$];
   int          n_checks = 0, n_pass = 0;
   int          gnt_dly = 0, rsp_dly = 0, err_wr_n = 0, abort_rd_n = -1;
   bit          rand_dly = 1'b0;
   int          stab_bad = 0;
   logic [31:0] salt = 32'h0;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ salt;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
   endtask

   // Memory-like bus target: programmable grant/response latency, logs every granted transaction
   initial begin : responder
      bit pend = 1'b0, abort_fired = 1'b0, rsp_err = 1'b0;
      int rcnt = 0, gcnt = 0, cur_gd = 0, rd_n = 0, wr_n = 0;
      logic [31:0] rsp_addr = 32'h0, f_addr = 32'h0, f_wdata = 32'h0;
      logic f_we = 1'b0;
      host_gnt_i = 1'b0; host_rvalid_i = 1'b0; host_err_i = 1'b0;
      host_rdata_i = 32'hDEAD_BEEF; abort_i = 1'b0;
      forever begin
         @(negedge clk);
         host_gnt_i = 1'b0; host_rvalid_i = 1'b0; host_err_i = 1'b0;
         host_rdata_i = 32'hDEAD_BEEF; abort_i = 1'b0;
         if (!busy_o) begin rd_n = 0; wr_n = 0; abort_fired = 1'b0; end
         if (!rst) begin
            pend = 1'b0; gcnt = 0;
         end else if (pend) begin
            if (rcnt == 0) begin
               host_rvalid_i = 1'b1;
               host_rdata_i  = mem_word(rsp_addr);
               host_err_i    = rsp_err;
               pend = 1'b0;
            end else rcnt--;
         end else if (host_req_o) begin
            if (gcnt == 0) begin
               cur_gd  = rand_dly ? int'($urandom_range(0, 3)) : gnt_dly;
               f_addr  = host_addr_o; f_wdata = host_wdata_o; f_we = host_we_o;
            end else if (host_addr_o !== f_addr || host_wdata_o !== f_wdata || host_we_o !== f_we) begin
               stab_bad++;
            end
            if (abort_rd_n >= 0 && !host_we_o && rd_n == abort_rd_n && !abort_fired) begin
               abort_i = 1'b1; abort_fired = 1'b1;
            end
            if (gcnt >= cur_gd) begin
               host_gnt_i = 1'b1; gcnt = 0; pend = 1'b1; rsp_addr = host_addr_o;
               rcnt = rand_dly ? int'($urandom_range(0, 3)) : rsp_dly;
               if (host_we_o) begin
                  wr_n++; rsp_err = (wr_n == err_wr_n);
                  log_q.push_back('{1'b1, host_addr_o, host_wdata_o});
               end else begin
                  rd_n++; rsp_err = 1'b0;
                  log_q.push_back('{1'b0, host_addr_o, 32'h0});
               end
            end else gcnt++;
         end
      end
   end

   // Model: word i is read from src+4i (or src) and written unchanged to dst+4i (or dst)
   task automatic build_exp(input logic [31:0] src, dst, input bit si, di, input int n_rd, n_wr);
      logic [31:0] ra, wa;
      exp_q.delete();
      for (int i = 0; i < n_rd; i++) begin
         ra = si ? src + 32'(4 * i) : src;
         exp_q.push_back('{1'b0, ra, 32'h0});
         if (i < n_wr) begin
            wa = di ? dst + 32'(4 * i) : dst;
            exp_q.push_back('{1'b1, wa, mem_word(ra)});
         end
      end
   endtask

   task automatic do_xfer(input logic [31:0] src, dst, input logic [15:0] len, input bit si, di,
                          input int restart_at, output int cycles);
      bit to;
      @(negedge clk);
      src_addr_i = src; dst_addr_i = dst; len_i = len;
      src_incr_i = si; dst_incr_i = di; start_i = 1'b1;
      cycles = 0; to = 1'b1;
      for (int k = 0; k < 3000; k++) begin
         @(posedge clk); #1;
         cycles++;
         if (cycles == 1) begin
            chk("start_busy", 32'(busy_o), 32'd1);
            chk("start_aborted_clr", 32'(aborted_o), 32'd0);
            chk("start_words_clr", 32'(words_done_o), 32'd0);
         end
         if (cycles == restart_at) begin
            start_i = 1'b1; src_addr_i = 32'hDEAD_0000; len_i = 16'd7;
         end else start_i = 1'b0;
         if (done_o) begin to = 1'b0; break; end
      end
      start_i = 1'b0;
      if (to) begin
         n_checks++;
         $display("FAIL xfer_timeout: got no done_o, expected done_o within 3000 cycles");
      end
   endtask

   task automatic check_end(input string name, input int exp_words, input bit exp_ab, input int base);
      chk({name, "_words"}, 32'(words_done_o), 32'(exp_words));
      chk({name, "_aborted"}, 32'(aborted_o), 32'(exp_ab));
      chk({name, "_irq"}, 32'(irq_o), 32'd1);
      chk({name, "_busy_at_done"}, 32'(busy_o), 32'd1);
      @(posedge clk); #1;
      chk({name, "_done_pulse"}, 32'(done_o), 32'd0);
      chk({name, "_busy_after"}, 32'(busy_o), 32'd0);
      chk({name, "_req_stable"}, 32'(stab_bad), 32'd0);
      chk({name, "_log_len"}, 32'(log_q.size() - base), 32'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && base + i < log_q.size(); i++) begin
         chk($sformatf("%s_txn%0d_we", name, i), 32'(log_q[base+i].we), 32'(exp_q[i].we));
         chk($sformatf("%s_txn%0d_addr", name, i), log_q[base+i].addr, exp_q[i].addr);
         chk($sformatf("%s_txn%0d_data", name, i), log_q[base+i].data, exp_q[i].data);
      end
   endtask

   initial begin : main
      vec_t vecs[5];
      int   cycles, base;
      logic [15:0] rl;
      salt = 32'h5A5A_0000 ^ $urandom;
      // expected cycles: 1 + len * 2 * (2 + grant_delay + response_delay)
      vecs[0] = '{"basic_fixed_dst", 32'h0010_0000, 32'h8000_5004, 16'd3, 1'b1, 1'b0, 0, 0, 13, 3};
      vecs[1] = '{"len_zero",        32'h0000_1000, 32'h0000_2000, 16'd0, 1'b1, 1'b1, 0, 0, 1, 0};
      vecs[2] = '{"gnt_delay3",      32'h0000_0400, 32'h0000_0800, 16'd3, 1'b1, 1'b1, 3, 0, 31, 3};
      vecs[3] = '{"src_wrap",        32'hFFFF_FFFC, 32'h0000_2000, 16'd2, 1'b1, 1'b1, 0, 1, 13, 2};
      vecs[4] = '{"both_fixed",      32'h0000_0040, 32'h8000_5004, 16'd5, 1'b0, 1'b0, 1, 2, 51, 5};

      repeat (3) @(negedge clk);
      chk("rst_busy", 32'(busy_o), 32'd0);
      chk("rst_done", 32'(done_o), 32'd0);
      chk("rst_aborted", 32'(aborted_o), 32'd0);
      chk("rst_irq", 32'(irq_o), 32'd0);
      chk("rst_words", 32'(words_done_o), 32'd0);
      chk("rst_req", 32'(host_req_o), 32'd0);
      chk("rst_we", 32'(host_we_o), 32'd0);
      chk("rst_addr", host_addr_o, 32'd0);
      chk("rst_wdata", host_wdata_o, 32'd0);
      chk("be_all_ones", 32'(host_be_o), 32'h0000_000F);
      rst = 1'b1;

      for (int v = 0; v < 5; v++) begin
         gnt_dly = vecs[v].gd; rsp_dly = vecs[v].rd;
         @(negedge clk); irq_clr_i = 1'b1;
         @(negedge clk); irq_clr_i = 1'b0;
         chk({vecs[v].name, "_irq_cleared"}, 32'(irq_o), 32'd0);
         base = log_q.size();
         build_exp(vecs[v].src, vecs[v].dst, vecs[v].si, vecs[v].di, int'(vecs[v].len), int'(vecs[v].len));
         do_xfer(vecs[v].src, vecs[v].dst, vecs[v].len, vecs[v].si, vecs[v].di, -1, cycles);
         chk({vecs[v].name, "_cycles"}, 32'(cycles), 32'(vecs[v].exp_cycles));
         check_end(vecs[v].name, vecs[v].exp_words, 1'b0, base);
      end

      // abort during the second read request: read finishes, its write is skipped
      gnt_dly = 2; rsp_dly = 0; abort_rd_n = 1;
      base = log_q.size();
      build_exp(32'h0000_3000, 32'h0000_4000, 1'b1, 1'b1, 2, 1);
      do_xfer(32'h0000_3000, 32'h0000_4000, 16'd4, 1'b1, 1'b1, -1, cycles);
      check_end("abort", 1, 1'b1, base);
      abort_rd_n = -1; gnt_dly = 0;

      // error response on the second write
      err_wr_n = 2;
      base = log_q.size();
`ifdef ACCEL_DMA_ERR_EN
      build_exp(32'h0000_5000, 32'h8000_5004, 1'b1, 1'b0, 2, 2);
      do_xfer(32'h0000_5000, 32'h8000_5004, 16'd3, 1'b1, 1'b0, -1, cycles);
      check_end("err_wr2", 1, 1'b1, base);
`else
      build_exp(32'h0000_5000, 32'h8000_5004, 1'b1, 1'b0, 3, 3);
      do_xfer(32'h0000_5000, 32'h8000_5004, 16'd3, 1'b1, 1'b0, -1, cycles);
      check_end("err_ignored", 3, 1'b0, base);
`endif
      err_wr_n = 0;

      // irq_clr_i held through completion: the set wins, the clear takes effect next cycle
      irq_clr_i = 1'b1;
      base = log_q.size();
      build_exp(32'h0000_9000, 32'h0000_A000, 1'b1, 1'b1, 1, 1);
      do_xfer(32'h0000_9000, 32'h0000_A000, 16'd1, 1'b1, 1'b1, -1, cycles);
      check_end("irq_set_wins", 1, 1'b0, base);
      chk("irq_clr_after", 32'(irq_o), 32'd0);
      irq_clr_i = 1'b0;

      // second start while busy is ignored
      base = log_q.size();
      build_exp(32'h0000_6000, 32'h0000_7000, 1'b1, 1'b0, 2, 2);
      do_xfer(32'h0000_6000, 32'h0000_7000, 16'd2, 1'b1, 1'b0, 3, cycles);
      check_end("start_ignored", 2, 1'b0, base);

      // asynchronous reset in the middle of the second word
      @(negedge clk);
      src_addr_i = 32'h0000_B000; dst_addr_i = 32'h0000_C000; len_i = 16'd4;
      src_incr_i = 1'b1; dst_incr_i = 1'b1; start_i = 1'b1;
      for (int k = 0; k < 40; k++) begin
         @(posedge clk); #1; start_i = 1'b0;
         if (host_req_o && words_done_o != 16'd0) break;
      end
      chk("mid_req_before_rst", 32'(host_req_o), 32'd1);
      #2 rst = 1'b0;
      #1;
      chk("async_rst_req", 32'(host_req_o), 32'd0);
      chk("async_rst_busy", 32'(busy_o), 32'd0);
      chk("async_rst_words", 32'(words_done_o), 32'd0);
      @(negedge clk); rst = 1'b1;
      repeat (2) @(negedge clk);

      // randomized transfers with random grant/response latencies
      rand_dly = 1'b1;
      for (int r = 0; r < 25; r++) begin
         logic [31:0] rs, rd;
         bit rsi, rdi;
         rl  = 16'($urandom_range(1, 6));
         rs  = $urandom & 32'hFFFF_FFFC;
         rd  = $urandom & 32'hFFFF_FFFC;
         rsi = 1'($urandom_range(0, 1));
         rdi = 1'($urandom_range(0, 1));
         base = log_q.size();
         build_exp(rs, rd, rsi, rdi, int'(rl), int'(rl));
         do_xfer(rs, rd, rl, rsi, rdi, -1, cycles);
         check_end($sformatf("rand%0d", r), int'(rl), 1'b0, base);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
